// File: rtl/sha256_pkg.sv
// Shared SHA-256 types: digest width and the match record carried through the collector FIFO.
package sha256_pkg;

  localparam int unsigned DIGEST_W    = 256;
  localparam int unsigned MATCH_IDX_W = 32;

  typedef struct packed {
    logic [MATCH_IDX_W-1:0] idx;
    logic [DIGEST_W-1:0]    digest;
  } MatchRec;

  // A bit takes part in the compare only where mask is 1.
  function automatic logic digest_match(input logic [DIGEST_W-1:0] d,
                                        input logic [DIGEST_W-1:0] t,
                                        input logic [DIGEST_W-1:0] m);
    return ((d ^ t) & m) == '0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with clear. A push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_axi,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full    = count == (AW+1)'(DEPTH);
    empty   = count == '0;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_axi) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_axi) begin
    if (!rst && !clr && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hash_match_collector.sv
// Compares each accepted digest against a masked target and queues matching {idx, digest}
// records; stalls upstream instead of ever dropping a digest.
module hash_match_collector
  import sha256_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDX_W      = 32
) (
  input  logic                clk_axi,
  input  logic                rst,
  input  logic                hash_vld,
  output logic                hash_rdy,
  input  logic [DIGEST_W-1:0] hash,
  input  logic                cfg_load,
  input  logic [DIGEST_W-1:0] cfg_target,
  input  logic [DIGEST_W-1:0] cfg_mask,
  output logic                match_vld,
  input  logic                match_rdy,
  output logic [IDX_W-1:0]    match_idx,
  output logic [DIGEST_W-1:0] match_hash,
  output logic [IDX_W-1:0]    hash_count,
  output logic [IDX_W-1:0]    match_count,
  output logic                armed,
  output logic                led
);

  localparam int unsigned REC_W = $bits(MatchRec) - MATCH_IDX_W + IDX_W;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  logic [DIGEST_W-1:0] target_q, mask_q, s1_hash_q;
  logic [IDX_W-1:0]    hash_count_q, match_count_q, s1_idx_q;
  logic                armed_q, led_q, s1_match_q;

  logic             hit, accept, push, pop;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             unused_fifo_count;

  assign unused_fifo_count = ^fifo_count;

  always_comb begin
    hit       = armed_q && digest_match(hash, target_q, mask_q);
    pop       = !fifo_empty && match_rdy;
    push      = s1_match_q && (!fifo_full || pop);
    // Only a match stuck in S1 (or a config load) ever blocks upstream.
    hash_rdy  = !cfg_load && !(s1_match_q && !push);
    accept    = hash_vld && hash_rdy;
    match_vld = !fifo_empty;
    match_idx  = fifo_empty ? '0 : fifo_rdata[REC_W-1 -: IDX_W];
    match_hash = fifo_empty ? '0 : fifo_rdata[DIGEST_W-1:0];
    hash_count  = hash_count_q;
    match_count = match_count_q;
    armed       = armed_q;
    led         = led_q;
  end

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      target_q      <= '0;
      mask_q        <= '0;
      armed_q       <= 1'b0;
      led_q         <= 1'b0;
      hash_count_q  <= '0;
      match_count_q <= '0;
      s1_match_q    <= 1'b0;
      s1_idx_q      <= '0;
      s1_hash_q     <= '0;
    end else if (cfg_load) begin
      target_q      <= cfg_target;
      mask_q        <= cfg_mask;
      armed_q       <= 1'b1;
      led_q         <= 1'b0;
      hash_count_q  <= '0;
      match_count_q <= '0;
      s1_match_q    <= 1'b0;
      s1_idx_q      <= '0;
      s1_hash_q     <= '0;
    end else begin
      // S1 only remembers matches; a non-match is simply not retained.
      if (accept) begin
        hash_count_q <= hash_count_q + IDX_W'(1);
        s1_match_q   <= hit;
        s1_idx_q     <= hash_count_q;
        s1_hash_q    <= hash;
      end else if (push) begin
        s1_match_q <= 1'b0;
      end
      if (push) begin
        match_count_q <= match_count_q + IDX_W'(1);
        led_q         <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_axi (clk_axi),
    .rst     (rst),
    .clr     (cfg_load),
    .push    (push),
    .wdata   ({s1_idx_q, s1_hash_q}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_hash_match_collector.sv
// Directed and randomized checks of hash_match_collector against a record-queue reference model.
module tb_hash_match_collector;

  logic         clk_axi = 1'b0;
  logic         rst;
  logic         hash_vld, hash_rdy, cfg_load, match_vld, match_rdy, armed, led;
  logic [255:0] hash, cfg_target, cfg_mask, match_hash;
  logic [31:0]  match_idx, hash_count, match_count;

  logic         w_hash_vld, w_hash_rdy, w_cfg_load, w_match_vld, w_match_rdy, w_armed, w_led;
  logic [255:0] w_hash, w_match_hash;
  logic [7:0]   w_match_idx, w_hash_count, w_match_count;

  int total = 0;
  int bad   = 0;

  always #5 clk_axi = ~clk_axi;

  hash_match_collector #(.FIFO_DEPTH(4), .IDX_W(32)) dut (
    .clk_axi (clk_axi), .rst (rst),
    .hash_vld (hash_vld), .hash_rdy (hash_rdy), .hash (hash),
    .cfg_load (cfg_load), .cfg_target (cfg_target), .cfg_mask (cfg_mask),
    .match_vld (match_vld), .match_rdy (match_rdy), .match_idx (match_idx),
    .match_hash (match_hash), .hash_count (hash_count), .match_count (match_count),
    .armed (armed), .led (led)
  );

  // Narrow-index instance so the index wrap is reachable in a short run.
  hash_match_collector #(.FIFO_DEPTH(2), .IDX_W(8)) dut_w (
    .clk_axi (clk_axi), .rst (rst),
    .hash_vld (w_hash_vld), .hash_rdy (w_hash_rdy), .hash (w_hash),
    .cfg_load (w_cfg_load), .cfg_target (cfg_target), .cfg_mask (cfg_mask),
    .match_vld (w_match_vld), .match_rdy (w_match_rdy), .match_idx (w_match_idx),
    .match_hash (w_match_hash), .hash_count (w_hash_count), .match_count (w_match_count),
    .armed (w_armed), .led (w_led)
  );

  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [255:0] t, input logic [255:0] m);
    cfg_target = t;
    cfg_mask   = m;
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [255:0] m_target, m_mask, d;
  logic [31:0]  exp_idx_q [$];
  logic [255:0] exp_hash_q [$];
  int           n_acc, n_hit, n_pop;
  logic         acc, seen_vld;

  initial begin
    rst = 1'b1; hash_vld = 0; hash = '0; cfg_load = 0; cfg_target = '0; cfg_mask = '0;
    match_rdy = 0; w_hash_vld = 0; w_hash = '0; w_cfg_load = 0; w_match_rdy = 0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_hash_rdy", hash_rdy, 1);
    chk("rst_match_vld", match_vld, 0);
    chk("rst_match_idx", match_idx, 0);
    chk("rst_match_hash", match_hash, 0);
    chk("rst_hash_count", hash_count, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_armed", armed, 0);
    chk("rst_led", led, 0);

    // Disarmed: digests counted, never matched (mask=0 would otherwise match all).
    seen_vld = 0;
    hash_vld = 1;
    for (int i = 0; i < 5; i++) begin
      hash = 256'(i + 7);
      tick();
      if (match_vld) seen_vld = 1;
    end
    chk("disarmed_count", hash_count, 5);
    chk("disarmed_no_vld", seen_vld, 0);
    cfg_target = 256'h1234; cfg_mask = '1; cfg_load = 1;
    #1;
    chk("cfgload_rdy_low", hash_rdy, 0);
    tick();
    cfg_load = 0;
    chk("cfgload_hash_cnt", hash_count, 0);
    chk("cfgload_match_cnt", match_count, 0);
    chk("cfgload_armed", armed, 1);
    hash = 256'h55;
    tick();
    hash_vld = 0;
    chk("post_load_accept", hash_count, 1);
    tick(); tick();
    chk("post_load_nomatch", match_vld, 0);

    // Exact compare: only digest 0 at index 1 matches.
    load('0, '1);
    hash_vld = 1;
    hash = 256'h1; tick();
    hash = 256'h0; tick();
    hash = 256'h2; tick();
    hash_vld = 0;
    tick(); tick();
    chk("exact_vld", match_vld, 1);
    chk("exact_idx", match_idx, 1);
    chk("exact_hash", match_hash, 0);
    chk("exact_match_cnt", match_count, 1);
    chk("exact_hash_cnt", hash_count, 3);
    chk("exact_led", led, 1);
    match_rdy = 1; tick(); match_rdy = 0;
    chk("exact_popped", match_vld, 0);

    // Latency: accept at edge N, visible after edge N+1, sampled by consumer at N+2.
    d = 256'hFF << 248;
    load('0, d);
    d = 256'h00AB << 240;
    hash = d; hash_vld = 1;
    #1;
    chk("lat_rdy", hash_rdy, 1);
    tick();
    hash_vld = 0;
    chk("lat_not_yet", match_vld, 0);
    tick();
    chk("lat_vld", match_vld, 1);
    chk("lat_idx", match_idx, 0);
    chk("lat_hash", match_hash, d);
    match_rdy = 1; tick(); match_rdy = 0;

    // Backpressure: mask=0 matches all; 4 stored, 5th held in S1.
    load(rand256(), '0);
    hash_vld = 1; n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      hash = 256'(100 + n_acc);
      #1;
      acc = hash_rdy;
      tick();
      if (acc) n_acc++;
    end
    chk("bp_accepts", n_acc, 5);
    chk("bp_hash_cnt", hash_count, 5);
    chk("bp_stored", match_count, 4);
    chk("bp_rdy_low", hash_rdy, 0);
    match_rdy = 1; n_pop = 0;
    for (int c = 0; c < 60 && n_pop < 10; c++) begin
      hash_vld = (n_acc < 10);
      hash = 256'(100 + n_acc);
      #1;
      acc = hash_vld && hash_rdy;
      if (match_vld && match_rdy) begin
        chk("bp_order_idx", match_idx, n_pop);
        chk("bp_order_hash", match_hash, 256'(100 + n_pop));
        n_pop++;
      end
      tick();
      if (acc) n_acc++;
    end
    hash_vld = 0; match_rdy = 0;
    chk("bp_all_popped", n_pop, 10);
    chk("bp_hash_cnt_end", hash_count, 10);
    chk("bp_match_cnt_end", match_count, 10);

    // Random traffic vs. record-queue model.
    m_target = rand256();
    m_mask   = 256'h7;
    load(m_target, m_mask);
    n_acc = 0; n_hit = 0;
    for (int c = 0; c < 400 + 60; c++) begin
      if (c >= 400 && exp_idx_q.size() == 0) break;
      hash_vld  = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      match_rdy = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
      hash      = rand256();
      #1;
      acc = hash_vld && hash_rdy;
      if (match_vld && match_rdy) begin
        chk("rand_expected_rec", exp_idx_q.size() != 0, 1);
        if (exp_idx_q.size() != 0) begin
          chk("rand_idx", match_idx, exp_idx_q.pop_front());
          chk("rand_hash", match_hash, exp_hash_q.pop_front());
        end
      end
      if (acc) begin
        if (((hash ^ m_target) & m_mask) == '0) begin
          exp_idx_q.push_back(32'(n_acc));
          exp_hash_q.push_back(hash);
          n_hit++;
        end
        n_acc++;
      end
      tick();
    end
    hash_vld = 0; match_rdy = 0;
    chk("rand_drained", exp_idx_q.size(), 0);
    chk("rand_vld_idle", match_vld, 0);
    chk("rand_hash_cnt", hash_count, n_acc);
    chk("rand_match_cnt", match_count, n_hit);

    // Reset with 3 records queued and a match parked in S1.
    load('0, '0);
    hash_vld = 1;
    for (int i = 0; i < 4; i++) begin
      hash = 256'(200 + i);
      tick();
    end
    hash_vld = 0;
    chk("pre_rst_stored", match_count, 3);
    chk("pre_rst_hash_cnt", hash_count, 4);
    rst = 1;
    tick();
    chk("mid_rst_vld", match_vld, 0);
    chk("mid_rst_hash_cnt", hash_count, 0);
    chk("mid_rst_match_cnt", match_count, 0);
    chk("mid_rst_armed", armed, 0);
    chk("mid_rst_led", led, 0);
    rst = 0;
    tick(); tick();
    chk("post_rst_vld", match_vld, 0);
    chk("post_rst_match_cnt", match_count, 0);
    chk("post_rst_rdy", hash_rdy, 1);

    // Index wrap on the narrow instance: 255 misses then a hit at idx 0xFF.
    cfg_target = '0; cfg_mask = '1; w_cfg_load = 1;
    tick();
    w_cfg_load = 0;
    w_hash_vld = 1;
    for (int i = 0; i < 256; i++) begin
      w_hash = (i == 255) ? 256'h0 : 256'h1;
      tick();
    end
    w_hash_vld = 0;
    tick();
    chk("wrap_vld", w_match_vld, 1);
    chk("wrap_idx", w_match_idx, 8'hFF);
    chk("wrap_hash_cnt", w_hash_count, 0);
    chk("wrap_match_cnt", w_match_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
